// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader:
// FSM state encoding, the fetch NOP word and the pc-to-word-index helper.
package imem_loader_pkg;

    localparam int          IMEM_DEPTH    = 256;
    localparam int          IMEM_ADDR_W   = 8;
    localparam logic [31:0] IMEM_NOP_WORD = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_LOAD = 2'b01,
        ST_RUN  = 2'b10
    } state_e;

    // Byte pc to word index; the full width is kept so out-of-range pcs stay visible.
    function automatic logic [31:0] pc_word_idx(input logic [31:0] pc);
        return pc >> 5'd2;
    endfunction

endpackage

// File: rtl/imem_ram.sv
// Instruction RAM: DEPTH x 32, one synchronous write port and one
// asynchronous read port for the single-cycle core's fetch path.
module imem_ram #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic              clock,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [31:0]       wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [31:0]       rdata
);

    logic [31:0] mem [DEPTH];

    // Write port; contents are deliberately not reset.
    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/imem_loader.sv
// Streams a program into the instruction RAM, stalls the CPU until the load
// completes, then serves zero-latency fetches with alignment/range checking.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int          DEPTH    = IMEM_DEPTH,
    parameter int          ADDR_W   = IMEM_ADDR_W,
    parameter logic [31:0] NOP_WORD = IMEM_NOP_WORD
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            load_start,
    input  logic [ADDR_W:0] load_len,
    input  logic            wr_valid,
    output logic            wr_ready,
    input  logic [31:0]     wr_data,
    input  logic [31:0]     cpu_pc,
    output logic [31:0]     cpu_inst,
    output logic            cpu_run,
    output logic            load_done,
    output logic            load_error,
    output logic            pc_fault
);

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] ONE_L   = (ADDR_W+1)'(1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] wptr_q, wptr_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic [ADDR_W:0]   loaded_len_q, loaded_len_d;
    logic              wr_ready_q, wr_ready_d;
    logic              cpu_run_q, cpu_run_d;
    logic              load_done_q, load_done_d;
    logic              load_error_q, load_error_d;
    logic              pc_fault_q, pc_fault_d;

    logic              len_ok_s;
    logic              accept_s;
    logic              last_word_s;
    logic              fetch_fault_s;
    logic              ram_we_s;
    logic [31:0]       word_idx_s;
    logic [31:0]       ram_rdata_s;

    assign len_ok_s    = (load_len != '0) && (load_len <= DEPTH_L);
    assign accept_s    = wr_valid & wr_ready_q;
    assign last_word_s = ({1'b0, wptr_q} == (len_q - ONE_L));
    assign word_idx_s  = pc_word_idx(cpu_pc);
    // Unsigned compare on the full word index so pc >= 4*DEPTH also faults.
    assign fetch_fault_s = (cpu_pc[1:0] != 2'b00) ||
                           (word_idx_s >= {{(31-ADDR_W){1'b0}}, loaded_len_q});

    imem_ram #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clock (clock),
        .we    (ram_we_s),
        .waddr (wptr_q),
        .wdata (wr_data),
        .raddr (word_idx_s[ADDR_W-1:0]),
        .rdata (ram_rdata_s)
    );

    // Next-state and registered-output logic of the load/run FSM.
    always_comb begin
        state_d      = state_q;
        wptr_d       = wptr_q;
        len_d        = len_q;
        loaded_len_d = loaded_len_q;
        wr_ready_d   = wr_ready_q;
        cpu_run_d    = cpu_run_q;
        load_done_d  = load_done_q;
        load_error_d = load_error_q;
        pc_fault_d   = pc_fault_q;
        ram_we_s     = 1'b0;
        case (state_q)
            ST_IDLE, ST_RUN: begin
                if ((state_q == ST_RUN) && fetch_fault_s) begin
                    pc_fault_d = 1'b1;
                end else begin
                    pc_fault_d = pc_fault_q;
                end
                if (load_start && len_ok_s) begin
                    state_d      = ST_LOAD;
                    wptr_d       = '0;
                    len_d        = load_len;
                    load_error_d = 1'b0;
                    wr_ready_d   = 1'b1;
                    cpu_run_d    = 1'b0;
                    load_done_d  = 1'b0;
                end else if (load_start) begin
                    load_error_d = 1'b1;
                end else begin
                    load_error_d = load_error_q;
                end
            end
            ST_LOAD: begin
                if (accept_s) begin
                    ram_we_s = 1'b1;
                    wptr_d   = wptr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                    if (last_word_s) begin
                        state_d      = ST_RUN;
                        wr_ready_d   = 1'b0;
                        load_done_d  = 1'b1;
                        cpu_run_d    = 1'b1;
                        loaded_len_d = len_q;
                        pc_fault_d   = 1'b0;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end else begin
                    ram_we_s = 1'b0;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                wr_ready_d  = 1'b0;
                cpu_run_d   = 1'b0;
                load_done_d = 1'b0;
            end
        endcase
    end

    // State and output registers; RAM contents survive reset, the load does not.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            wptr_q       <= '0;
            len_q        <= '0;
            loaded_len_q <= '0;
            wr_ready_q   <= 1'b0;
            cpu_run_q    <= 1'b0;
            load_done_q  <= 1'b0;
            load_error_q <= 1'b0;
            pc_fault_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            wptr_q       <= wptr_d;
            len_q        <= len_d;
            loaded_len_q <= loaded_len_d;
            wr_ready_q   <= wr_ready_d;
            cpu_run_q    <= cpu_run_d;
            load_done_q  <= load_done_d;
            load_error_q <= load_error_d;
            pc_fault_q   <= pc_fault_d;
        end
    end

    // Fetch mux: NOP outside RUN and for misaligned or out-of-range pcs.
    always_comb begin
        cpu_inst = NOP_WORD;
        if ((state_q == ST_RUN) && !fetch_fault_s) begin
            cpu_inst = ram_rdata_s;
        end else begin
            cpu_inst = NOP_WORD;
        end
    end

    assign wr_ready   = wr_ready_q;
    assign cpu_run    = cpu_run_q;
    assign load_done  = load_done_q;
    assign load_error = load_error_q;
    assign pc_fault   = pc_fault_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: a small behavioural model predicts
// flags and fetch results; fetch expectations flow through a scoreboard queue.
module tb_imem_loader;

    localparam int DEPTH  = 256;
    localparam int ADDR_W = 8;

    logic            clock = 1'b0;
    logic            reset_n;
    logic            load_start;
    logic [ADDR_W:0] load_len;
    logic            wr_valid;
    logic            wr_ready;
    logic [31:0]     wr_data;
    logic [31:0]     cpu_pc;
    logic [31:0]     cpu_inst;
    logic            cpu_run;
    logic            load_done;
    logic            load_error;
    logic            pc_fault;

    imem_loader dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .load_start (load_start),
        .load_len   (load_len),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_data    (wr_data),
        .cpu_pc     (cpu_pc),
        .cpu_inst   (cpu_inst),
        .cpu_run    (cpu_run),
        .load_done  (load_done),
        .load_error (load_error),
        .pc_fault   (pc_fault)
    );

    always #5 clock = ~clock;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_q [$];
    logic [31:0] wq [$];
    logic [31:0] mdl_mem [DEPTH];
    int          mdl_len = 0;
    bit          mdl_ready = 1'b0, mdl_run = 1'b0, mdl_done = 1'b0;
    bit          mdl_err = 1'b0, mdl_fault = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_outs(input string tag);
        check_val({tag, " flags(rdy,run,done,err,flt)"},
                  {27'd0, wr_ready, cpu_run, load_done, load_error, pc_fault},
                  {27'd0, mdl_ready, mdl_run, mdl_done, mdl_err, mdl_fault});
    endtask

    function automatic bit mdl_bad_pc(input logic [31:0] pc);
        return (pc[1:0] != 2'b00) || ({2'b00, pc[31:2]} >= 32'(mdl_len));
    endfunction

    function automatic logic [31:0] mdl_fetch(input logic [31:0] pc);
        if (!mdl_run || mdl_bad_pc(pc)) return 32'h0000_0000;
        return mdl_mem[pc[9:2]];
    endfunction

    // Drive a pc, check the combinational fetch, then hold it across an edge.
    task automatic fetch(input string tag, input logic [31:0] pc);
        cpu_pc = pc;
        exp_q.push_back(mdl_fetch(pc));
        #1;
        check_val(tag, cpu_inst, exp_q.pop_front());
        if (mdl_run && mdl_bad_pc(pc)) mdl_fault = 1'b1;
        tick();
        check_outs(tag);
        cpu_pc = 32'd0;
    endtask

    task automatic start(input string tag, input int len);
        load_start = 1'b1;
        load_len   = (ADDR_W+1)'(len);
        tick();
        load_start = 1'b0;
        if (len >= 1 && len <= DEPTH) begin
            mdl_ready = 1'b1; mdl_run = 1'b0; mdl_done = 1'b0; mdl_err = 1'b0;
        end else begin
            mdl_err = 1'b1;
        end
        check_outs(tag);
    endtask

    // Stream wq with a repeating valid pattern (plen=0 means valid held high).
    task automatic stream(input string tag, input logic [15:0] pat, input int plen, input int exp_cyc);
        int idx = 0;
        int cyc = 0;
        while (idx < wq.size() && cyc < 2000) begin
            wr_valid = (plen == 0) ? 1'b1 : pat[cyc % plen];
            wr_data  = wq[idx];
            tick();
            if (wr_valid) begin
                mdl_mem[idx] = wq[idx];
                idx++;
            end
            cyc++;
            if (idx == wq.size()) begin
                mdl_ready = 1'b0; mdl_run = 1'b1; mdl_done = 1'b1; mdl_fault = 1'b0;
                mdl_len = wq.size();
            end
            if (wq.size() <= 8 || idx == wq.size()) check_outs(tag);
        end
        wr_valid = 1'b0;
        check_val({tag, " cycles"}, 32'(cyc), 32'(exp_cyc));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n = 1'b0; load_start = 1'b0; load_len = '0;
        wr_valid = 1'b0; wr_data = 32'd0; cpu_pc = 32'd0;
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
        tick();
        check_outs("reset");
        fetch("idle fetch", 32'd0);

        start("len0", 0);
        fetch("len0 idle fetch", 32'd0);
        start("len257", DEPTH + 1);

        wq = {32'h2008_0005, 32'h2009_0007, 32'h0109_5020};
        start("load3", 3);
        stream("load3 held", 16'h0000, 0, 3);
        fetch("pc0", 32'd0);
        fetch("pc4", 32'd4);
        fetch("pc8", 32'd8);

        wq = {32'hA5A5_0001, 32'h5A5A_0002, 32'h1234_5678};
        start("reload3", 3);
        stream("reload3 toggled", 16'b0000_0000_0010_1001, 6, 6);
        fetch("re pc0", 32'd0);
        fetch("re pc4", 32'd4);
        fetch("re pc8", 32'd8);

        fetch("pc12 out of range", 32'd12);
        fetch("pc2 misaligned", 32'd2);
        fetch("pc0 sticky", 32'd0);
        fetch("pc1024 wrap", 32'd1024);

        start("run len0", 0);
        fetch("run after err", 32'd4);

        wq = {32'hCAFE_0000, 32'hCAFE_0001};
        start("load2", 2);
        fetch("load fetch nop", 32'd4);
        stream("load2", 16'h0000, 0, 2);
        wr_valid = 1'b1;
        wr_data  = 32'hBAD0_BAD0;
        tick();
        wr_valid = 1'b0;
        check_outs("beyond len");
        fetch("l2 pc4", 32'd4);
        fetch("l2 pc8 fault", 32'd8);

        wq.delete();
        for (int i = 0; i < DEPTH; i++) wq.push_back(32'h0F00_0000 ^ (32'(i) * 32'h0001_0103));
        start("full", DEPTH);
        stream("full", 16'h0000, 0, DEPTH);
        fetch("full pc1020", 32'd1020);
        fetch("full pc512", 32'd512);
        fetch("full pc1024 fault", 32'd1024);

        wq = {32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444};
        start("load4", 4);
        wr_valid = 1'b1;
        wr_data  = wq[0];
        tick();
        mdl_mem[0] = wq[0];
        check_outs("load4 word1");
        wr_data = 32'hDEAD_BEEF;
        #2;
        reset_n = 1'b0;
        #1;
        mdl_ready = 1'b0; mdl_run = 1'b0; mdl_done = 1'b0;
        mdl_err = 1'b0; mdl_fault = 1'b0; mdl_len = 0;
        check_outs("async reset");
        tick();
        check_outs("in reset");
        wr_valid = 1'b0;
        reset_n  = 1'b1;
        tick();
        check_outs("after reset");
        fetch("after reset fetch", 32'd0);

        wq = {32'h7777_0001};
        start("load1", 1);
        stream("load1", 16'h0000, 0, 1);
        fetch("l1 pc0", 32'd0);
        fetch("l1 pc4 fault", 32'd4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
